// File: rtl/jt900h_div_ctl_pkg.sv
// Shared definitions for the DIV/DIVS sequencer: state encoding and operand length widths.
package jt900h_div_ctl_pkg;

    localparam int unsigned ST_W   = 3;
    localparam int unsigned W_BYTE = 8;
    localparam int unsigned W_WORD = 16;

    typedef enum logic [ST_W-1:0] {
        StIdle   = 3'd0,
        StAbs    = 3'd1,
        StLaunch = 3'd2,
        StWaitb  = 3'd3,
        StWaite  = 3'd4,
        StFix    = 3'd5,
        StDone   = 3'd6
    } div_st_t;

endpackage

// File: rtl/jt900h_div_ctl_if.sv
// ALU request/result handshake plus the start/busy link to the shared divider datapath.
interface jt900h_div_ctl_if #(
    parameter int unsigned DW = 16
);
    logic          cen;
    logic          req;
    logic          sgn;
    logic          len;
    logic [DW-1:0] dvd;
    logic [DW-1:0] dvs;
    logic          busy;
    logic          done;
    logic [DW-1:0] quot;
    logic [DW-1:0] rem;
    logic          v;
    logic          div_start;
    logic          div_len;
    logic [DW-1:0] div_op0;
    logic [DW-1:0] div_op1;
    logic          div_busy;
    logic [DW-1:0] div_quot;
    logic [DW-1:0] div_rem;

    modport slave (
        input  cen, req, sgn, len, dvd, dvs, div_busy, div_quot, div_rem,
        output busy, done, quot, rem, v, div_start, div_len, div_op0, div_op1
    );

    modport master (
        output cen, req, sgn, len, dvd, dvs, div_busy, div_quot, div_rem,
        input  busy, done, quot, rem, v, div_start, div_len, div_op0, div_op1
    );
endinterface

// File: rtl/jt900h_div_sgn.sv
// Conditional two's-complement negate over the active length (8 or 16 bits), zero-extended.
module jt900h_div_sgn
    import jt900h_div_ctl_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic          len,
    input  logic          neg,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] neg_din;

    always_comb begin
        neg_din = neg ? (~din + DW'(1)) : din;
        dout    = len ? neg_din : {{(DW-W_BYTE){1'b0}}, neg_din[W_BYTE-1:0]};
    end

endmodule

// File: rtl/jt900h_div_ctl.sv
// DIV/DIVS sequencer: sign magnitude conversion, divider launch, sign restore and V flag.
// Optional JT900H_DIVCTL_TRIV_EN: divisor magnitude 1 bypasses the divider.
module jt900h_div_ctl
    import jt900h_div_ctl_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input logic             rst,
    input logic             clk,
    jt900h_div_ctl_if.slave bus
);

    div_st_t       st;
    logic          lsgn, llen;
    logic [DW-1:0] ldvd, ldvs;
    logic [DW-1:0] mquot, mrem;
    logic          neg_q, neg_r, dz;

    logic          sd, ss, ovf;
    logic [DW-1:0] mag0, mag1, fquot, frem;
    logic [DW-1:0] ones_n, msb_n, dvd_n;

    always_comb begin
        sd     = lsgn & (llen ? ldvd[DW-1] : ldvd[W_BYTE-1]);
        ss     = lsgn & (llen ? ldvs[DW-1] : ldvs[W_BYTE-1]);
        ones_n = llen ? {DW{1'b1}} : {{(DW-W_BYTE){1'b0}}, {W_BYTE{1'b1}}};
        msb_n  = llen ? {1'b1, {(DW-1){1'b0}}}
                      : {{(DW-W_BYTE){1'b0}}, 1'b1, {(W_BYTE-1){1'b0}}};
        dvd_n  = ldvd & ones_n;
        // A positive signed result cannot reach 2^(n-1); only -min / -1 gets there
        ovf    = lsgn & ~neg_q & |(mquot & msb_n);
    end

    jt900h_div_sgn #(.DW(DW)) u_abs0 (.len(llen), .neg(sd),    .din(ldvd),  .dout(mag0));
    jt900h_div_sgn #(.DW(DW)) u_abs1 (.len(llen), .neg(ss),    .din(ldvs),  .dout(mag1));
    jt900h_div_sgn #(.DW(DW)) u_fixq (.len(llen), .neg(neg_q), .din(mquot), .dout(fquot));
    jt900h_div_sgn #(.DW(DW)) u_fixr (.len(llen), .neg(neg_r), .din(mrem),  .dout(frem));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= StIdle;
            lsgn          <= 1'b0;
            llen          <= 1'b0;
            ldvd          <= '0;
            ldvs          <= '0;
            mquot         <= '0;
            mrem          <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quot      <= '0;
            bus.rem       <= '0;
            bus.v         <= 1'b0;
            bus.div_start <= 1'b0;
            bus.div_len   <= 1'b0;
            bus.div_op0   <= '0;
            bus.div_op1   <= '0;
        end else if (bus.cen) begin
            unique case (st)
                StIdle: begin
                    if (bus.req) begin
                        lsgn     <= bus.sgn;
                        llen     <= bus.len;
                        ldvd     <= bus.dvd;
                        ldvs     <= bus.dvs;
                        bus.busy <= 1'b1;
                        st       <= StAbs;
                    end
                end
                StAbs: begin
                    neg_q <= sd ^ ss;
                    neg_r <= sd;
                    dz    <= (mag1 == '0);
                    if (mag1 == '0) begin
                        st <= StFix;
`ifdef JT900H_DIVCTL_TRIV_EN
                    end else if (mag1 == DW'(1)) begin
                        mquot <= mag0;
                        mrem  <= '0;
                        st    <= StFix;
`endif
                    end else begin
                        bus.div_start <= 1'b1;
                        bus.div_len   <= llen;
                        bus.div_op0   <= mag0;
                        bus.div_op1   <= mag1;
                        st            <= StLaunch;
                    end
                end
                StLaunch: begin
                    bus.div_start <= 1'b0;
                    st            <= StWaitb;
                end
                StWaitb: begin
                    if (bus.div_busy) st <= StWaite;
                end
                StWaite: begin
                    if (!bus.div_busy) begin
                        mquot <= bus.div_quot & ones_n;
                        mrem  <= bus.div_rem & ones_n;
                        st    <= StFix;
                    end
                end
                StFix: begin
                    if (dz) begin
                        bus.quot <= ones_n;
                        bus.rem  <= dvd_n;
                        bus.v    <= 1'b1;
                    end else if (ovf) begin
                        bus.quot <= msb_n;
                        bus.rem  <= '0;
                        bus.v    <= 1'b1;
                    end else begin
                        bus.quot <= fquot;
                        bus.rem  <= frem;
                        bus.v    <= 1'b0;
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    st       <= StDone;
                end
                StDone: begin
                    bus.done <= 1'b0;
                    st       <= StIdle;
                end
                default: st <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jt900h_div_ctl.sv
// Scoreboard bench for jt900h_div_ctl with a behavioural multi-cycle divider.
// Honours JT900H_DIVCTL_TRIV_EN when expecting latency and divider use.
module tb_jt900h_div_ctl;

    localparam int unsigned DW = 16;

    typedef struct {
        string       name;
        logic [15:0] q;
        logic [15:0] r;
        logic        v;
        int          lat;
        int          ns;
        int          t0;
        int          s0;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jt900h_div_ctl_if #(.DW(DW)) bus ();

    jt900h_div_ctl #(.DW(DW)) dut (
        .rst (rst),
        .clk (clk),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   ccnt = 0;
    int   nstart = 0;
    int   div_l = 4;
    int   cen_mode = 0;
    int   cen_ph = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural divider: busy for div_l cen cycles, results valid only once busy drops
    logic [15:0] dmask, dq, dr;
    int          dcnt;
    assign dmask = bus.div_len ? 16'hFFFF : 16'h00FF;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.div_busy <= 1'b0;
            bus.div_quot <= '0;
            bus.div_rem  <= '0;
            dcnt         <= 0;
            dq           <= '0;
            dr           <= '0;
        end else if (bus.cen) begin
            if (bus.div_start && !bus.div_busy) begin
                bus.div_busy <= 1'b1;
                bus.div_quot <= 16'hDEAD;
                bus.div_rem  <= 16'hBEEF;
                dcnt         <= div_l;
                if ((bus.div_op1 & dmask) != 0) begin
                    dq <= (bus.div_op0 & dmask) / (bus.div_op1 & dmask);
                    dr <= (bus.div_op0 & dmask) % (bus.div_op1 & dmask);
                end
            end else if (bus.div_busy) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    bus.div_busy <= 1'b0;
                    bus.div_quot <= dq;
                    bus.div_rem  <= dr;
                end
            end
        end
    end

    initial begin
        bus.cen = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cen_ph  = (cen_ph + 1) % 3;
            bus.cen = (cen_mode == 0) || (cen_ph == 0);
        end
    end

    always @(posedge clk) if (bus.cen && !rst) ccnt <= ccnt + 1;

    // Negedge with cen=1 is the last sample point of a cen cycle
    always @(negedge clk) begin
        if (!rst && bus.cen) begin
            if (bus.div_start) nstart <= nstart + 1;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 16'(bus.done), 16'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, ".quot"}, bus.quot, e.q);
                    check({e.name, ".rem"}, bus.rem, e.r);
                    check({e.name, ".v"}, 16'(bus.v), 16'(e.v));
                    check({e.name, ".lat"}, 16'(ccnt - e.t0 + 1), 16'(e.lat));
                    check({e.name, ".starts"}, 16'(nstart - e.s0), 16'(e.ns));
                end
            end
        end
    end

    function automatic exp_t model(input string name, input bit s, input bit l,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        longint      av, bv, q, r, mask, half;
        logic [7:0]  a8, b8;
        a8   = a[7:0];
        b8   = b[7:0];
        mask = l ? 64'hFFFF : 64'hFF;
        half = l ? 32768 : 128;
        if (l) begin
            av = s ? longint'($signed(a)) : longint'(a);
            bv = s ? longint'($signed(b)) : longint'(b);
        end else begin
            av = s ? longint'($signed(a8)) : longint'(a8);
            bv = s ? longint'($signed(b8)) : longint'(b8);
        end
        e.name = name;
        e.ns   = 1;
        e.lat  = div_l + 5;
        e.t0   = 0;
        e.s0   = 0;
        if (bv == 0) begin
            e.q   = 16'(mask);
            e.r   = 16'(av & mask);
            e.v   = 1'b1;
            e.ns  = 0;
            e.lat = 3;
        end else begin
            q = av / bv;
            r = av % bv;
            if (s && q >= half) begin
                e.q = 16'(half);
                e.r = '0;
                e.v = 1'b1;
            end else begin
                e.q = 16'(q & mask);
                e.r = 16'(r & mask);
                e.v = 1'b0;
            end
`ifdef JT900H_DIVCTL_TRIV_EN
            if (bv == 1 || bv == -1) begin
                e.ns  = 0;
                e.lat = 3;
            end
`endif
        end
        return e;
    endfunction

    task automatic issue(input string name, input bit s, input bit l,
                         input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   guard;
        guard = 0;
        while ((bus.busy || bus.done) && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) check({name, ".idle_timeout"}, 16'(bus.busy), 16'h0);
        bus.sgn = s;
        bus.len = l;
        bus.dvd = a;
        bus.dvs = b;
        bus.req = 1'b1;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!bus.cen && guard < 10);
        #1;
        bus.req = 1'b0;
        e    = model(name, s, l, a, b);
        e.t0 = ccnt;
        e.s0 = nstart;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (sb.size() != 0) begin
            check({name, ".drain_timeout"}, 16'(sb.size()), 16'h0);
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input int l_cyc, input bit s, input bit l,
                       input logic [15:0] a, input logic [15:0] b);
        div_l = l_cyc;
        issue(name, s, l, a, b);
        drain(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst     = 1'b1;
        bus.req = 1'b0;
        bus.sgn = 1'b0;
        bus.len = 1'b0;
        bus.dvd = '0;
        bus.dvs = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 16'(bus.busy), 16'h0);
        check("rst.done", 16'(bus.done), 16'h0);
        check("rst.quot", bus.quot, 16'h0);
        check("rst.rem", bus.rem, 16'h0);
        check("rst.v", 16'(bus.v), 16'h0);
        check("rst.div_start", 16'(bus.div_start), 16'h0);
        check("rst.div_len", 16'(bus.div_len), 16'h0);
        check("rst.div_op0", bus.div_op0, 16'h0);
        check("rst.div_op1", bus.div_op1, 16'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("u_w_1000_7", 4, 1'b0, 1'b1, 16'd1000, 16'd7);
        run("s_w_m7_2", 3, 1'b1, 1'b1, 16'hFFF9, 16'h0002);
        run("s_b_7_m2", 1, 1'b1, 1'b0, 16'h0007, 16'h00FE);
        run("u_w_dz", 4, 1'b0, 1'b1, 16'h1234, 16'h0000);
        run("s_b_dz", 2, 1'b1, 1'b0, 16'hA5C3, 16'h7700);
        run("s_b_ovf", 2, 1'b1, 1'b0, 16'h0080, 16'h00FF);
        run("u_b_80_ff", 2, 1'b0, 1'b0, 16'h0080, 16'h00FF);
        run("s_w_ovf", 5, 1'b1, 1'b1, 16'h8000, 16'hFFFF);
        run("s_w_min_1", 2, 1'b1, 1'b1, 16'h8000, 16'h0001);
        run("u_w_5a5a_1", 3, 1'b0, 1'b1, 16'h5A5A, 16'h0001);
        run("u_b_hibits", 2, 1'b0, 1'b0, 16'hAB14, 16'hCD03);
        run("s_b_m100_7", 6, 1'b1, 1'b0, 16'h009C, 16'h0007);
        run("s_w_100_m7", 2, 1'b1, 1'b1, 16'd100, 16'hFFF9);

        // req pulses while busy must neither restart nor corrupt the running request
        div_l = 6;
        issue("busy_req", 1'b1, 1'b1, 16'hFF9C, 16'd9);
        repeat (2) @(posedge clk);
        #1;
        bus.req = 1'b1;
        bus.sgn = 1'b0;
        bus.len = 1'b0;
        bus.dvd = 16'h0011;
        bus.dvs = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        bus.req = 1'b0;
        drain("busy_req");

        // Reset while the divider is running
        div_l = 10;
        issue("rst_mid", 1'b0, 1'b1, 16'd5000, 16'd3);
        guard = 0;
        while (!bus.div_busy && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("rst_mid.div_busy_seen", 16'(bus.div_busy), 16'h1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid.busy", 16'(bus.busy), 16'h0);
        check("rst_mid.done", 16'(bus.done), 16'h0);
        check("rst_mid.div_start", 16'(bus.div_start), 16'h0);
        check("rst_mid.quot", bus.quot, 16'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run("after_rst", 3, 1'b0, 1'b1, 16'd1000, 16'd7);

        cen_mode = 1;
        run("cen3_u_w", 4, 1'b0, 1'b1, 16'd1000, 16'd7);
        run("cen3_s_b", 2, 1'b1, 1'b0, 16'h0007, 16'h00FE);
        run("cen3_dz", 2, 1'b0, 1'b1, 16'h1234, 16'h0000);
        run("cen3_ovf", 3, 1'b1, 1'b0, 16'h0080, 16'h00FF);
        cen_mode = 0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) b = -b;
            run($sformatf("rnd%0d", i), int'($urandom_range(1, 6)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jt900h_div_ctl.md
Name: jt900h_div_ctl

Overview:
Sequencer between the ALU's DIV/DIVS micro-ops and the shared unsigned divider datapath.
- Accepts one signed or unsigned request, in byte or word length, and converts the operands to magnitudes.
- Launches the divider through its start/busy interface and waits for it to finish.
- Restores the result signs and flags divide-by-zero and signed overflow on V.
- The ALU sees a single req/done handshake and never drives the divider directly.

Parameters:
- DW, 16: maximum operand width. The word length uses all DW bits; the byte length uses bits [7:0].

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- cen  in  1  clock enable; state and registers advance only when cen=1
- req  in  1  request strobe; sampled in IDLE when cen=1
- sgn  in  1  1 = signed (DIVS), 0 = unsigned (DIV)
- len  in  1  1 = word, 0 = byte
- dvd  in  DW  dividend
- dvs  in  DW  divisor
- busy  out  1  request in progress
- done  out  1  one-cycle result-valid pulse
- quot  out  DW  quotient
- rem  out  DW  remainder
- v  out  1  overflow / divide-by-zero flag
- div_start  out  1  start pulse to the divider
- div_len  out  1  length to the divider
- div_op0  out  DW  dividend magnitude
- div_op1  out  DW  divisor magnitude
- div_busy  in  1  divider busy; rises on the cen cycle after div_start
- div_quot  in  DW  divider quotient, unsigned
- div_rem  in  DW  divider remainder, unsigned

Behaviour:
- Reset values: every output is 0; state is IDLE.
- Reset mid-operation returns the block to IDLE immediately, with div_start=0 and no done pulse.
- States: IDLE, ABS, LAUNCH, WAITB, WAITE, FIX, DONE.
- All transitions are qualified by cen.
- IDLE:
  - On req, latch sgn, len, dvd and dvs; set busy=1; go to ABS.
  - req while busy=1 is ignored. There is no queue.
- ABS:
  - Working width n = 16 if len=1, else 8. For byte length, bits [DW-1:8] of the inputs are ignored.
  - If sgn=1 and an operand is negative, replace it with its two's-complement magnitude (n bits). Otherwise use the operand unchanged.
  - Record neg_q = sd ^ ss and neg_r = sd, where sd and ss are the operand sign bits (0 when sgn=0).
  - If the divisor is zero, go to FIX with the dz flag set. Otherwise go to LAUNCH.
- LAUNCH:
  - div_start=1 for exactly one cen cycle.
  - div_len = len.
  - div_op0 and div_op1 carry the magnitudes, zero-extended for byte length.
  - Next state is WAITB.
- WAITB: wait for div_busy=1, then go to WAITE. This guards against the one-cycle start→busy lag.
- WAITE: wait for div_busy=0, capture div_quot and div_rem, go to FIX.
- FIX:
  - Quotient is negated if neg_q; remainder is negated if neg_r. Results are truncated to n bits and zero-extended to DW.
  - dz: quot = all-ones (n bits), rem = dvd[n-1:0], v = 1.
  - Signed overflow (neg_q=0 and the magnitude quotient ≥ 2^(n-1)): quot = 2^(n-1), rem = 0, v = 1. Example: -128/-1 byte, -32768/-1 word.
  - Otherwise v = 0.
  - Unsigned divisions never overflow.
- DONE: done=1 for one cen cycle; busy falls at the same edge. Next state is IDLE.
- Output hold: quot, rem and v hold until the next FIX.
- Latency from req to done, for a divider taking L busy cycles: L+5 cen cycles. Divide-by-zero: 3 cen cycles.

Optional Feature:
JT900H_DIVCTL_TRIV_EN
- Defined: ABS also detects a divisor magnitude of 1. The block skips LAUNCH/WAITB/WAITE, forms quot = dividend magnitude and rem = 0, then applies FIX normally, overflow check included. Latency is 3 cycles and div_start is never pulsed.
- Not defined: every non-zero divisor goes through the divider.

Decomposition:
- Shared include/package holds:
  - state encoding localparams, 3 bits;
  - length constants: byte width 8, word width 16.
- One sub-module, jt900h_div_sgn: combinational n-bit conditional negate, selected by len. It is instantiated for the operand conversion in ABS and for the result restore in FIX.

Test Plan:
- Unsigned word 1000/7 → quot=0x008E, rem=0x0006, v=0, one div_start pulse, done after L+5.
- Signed word -7/2 (0xFFF9/0x0002) → quot=0xFFFD, rem=0xFFFF, v=0. Signed byte 0x07/0xFE → quot=0x00FD, rem=0x0001.
- Divide by zero, word 0x1234/0 → quot=0xFFFF, rem=0x1234, v=1, div_start never asserted, done at cycle 3.
- Signed byte 0x80/0xFF → quot=0x0080, rem=0, v=1. The same operands unsigned → quot=0x0000, rem=0x0080, v=0.
- Reset and cen handling:
  - Assert rst during WAITE → busy=0, done=0, next req is accepted normally.
  - cen toggling 1-of-3 → results identical, latency scaled in cen cycles.
  - req while busy is ignored.
- With JT900H_DIVCTL_TRIV_EN defined: 0x5A5A/1 → quot=0x5A5A, rem=0, no div_start. Without the macro → same results via the divider.
